ccg_response_misr: RTL

Response compactor that sits directly downstream of a generated combinational benchmark netlist (4 inputs, 6 outputs). It accepts one output vector per handshake and folds it into a multiple-input signature register (MISR). After a programmed number of vectors it compares the final signature with an expected value and reports pass/fail. It lets a test pattern sweep, such as all 16 input combinations, be checked against a golden signature without storing every response.

---
 rtl/ccg_response_misr.sv | 116 +++++++++++
 1 files changed

// File: rtl/ccg_response_misr.sv
// Response compactor: folds benchmark output vectors into a MISR signature.
// After NVEC vectors it compares the signature to a golden value.
module ccg_response_misr #(
  parameter int               IN_W  = 6,
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = 16'h1021,
  parameter logic [SIG_W-1:0] SEED  = 16'hFFFF,
  parameter int               NVEC  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [SIG_W-1:0] expected,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] sig,
  output logic [15:0]      vec_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [SIG_W-1:0] r_sig;
  logic [SIG_W-1:0] w_shift;
  logic [SIG_W-1:0] w_sigNext;
  logic [15:0]      r_cnt;
  logic             r_pass;
  logic             w_accept;
  logic             w_last;

  // Shift with the MSB feeding back through the polynomial, then fold in the vector.
  always_comb begin
    w_shift = {r_sig[SIG_W-2:0], 1'b0};
    if (r_sig[SIG_W-1]) begin
      w_shift = w_shift ^ POLY;
    end
    w_sigNext = w_shift ^ SIG_W'(in_data);
  end

  assign w_accept = in_valid && (r_state == S_RUN);
  assign w_last   = (r_cnt == 16'(NVEC - 1));

  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = S_RUN;
        end
      end
      S_RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (w_accept && w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sig   <= SEED;
      r_cnt   <= 16'd0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sig  <= SEED;
            r_cnt  <= 16'd0;
            r_pass <= 1'b0;
          end
        end
        S_RUN: begin
          if (w_accept) begin
            r_sig <= w_sigNext;
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_DONE: begin
          r_pass <= (r_sig == expected);
        end
        default: begin
        end
      endcase
    end
  end

  assign sig     = r_sig;
  assign vec_cnt = r_cnt;
  assign pass    = r_pass;

endmodule
